// File: rtl/taller_alarm_pkg.sv
// rtl/taller_alarm_pkg.sv - shared constants, state encoding and BCD helpers for the alarm clock
package taller_alarm_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_TIME_HM  = 3'd2;
  localparam logic [2:0] ADDR_TIME_S   = 3'd3;
  localparam logic [2:0] ADDR_ALARM_HM = 3'd4;
  localparam logic [2:0] ADDR_COUNT    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZED = 2'b10
  } state_e;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ALARM_EN = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_SNOOZE   = 3;
  localparam int CTRL_STOP     = 4;

  localparam int STAT_FIRED = 0;
  localparam int STAT_WERR  = 1;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_HR = 8'h23;

  // With both digits valid, binary ordering of BCD bytes matches numeric ordering.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/taller_alarm_clock_if.sv
// rtl/taller_alarm_clock_if.sv - Avalon-MM register bus between host and alarm clock
interface taller_alarm_clock_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/taller_bcd_digit_pair.sv
// rtl/taller_bcd_digit_pair.sv - two-digit BCD counter wrapping after MAX, with load and carry-out
module taller_bcd_digit_pair
  import taller_alarm_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] value,
  output logic       carry
);
  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      value_d = (value_q == MAX) ? 8'h00 : bcd_inc(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= 8'h00;
    else        value_q <= value_d;
  end

  assign value = value_q;
  assign carry = en && !load && (value_q == MAX);
endmodule

// File: rtl/taller_alarm_clock.sv
// rtl/taller_alarm_clock.sv - BCD time-of-day core with alarm match, ring/snooze FSM and register file
module taller_alarm_clock
  import taller_alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic                       clk,
  input  logic                       reset_n,
  taller_alarm_clock_if.slave        bus,
  input  logic                       tick,
  output logic                       irq,
  output logic                       alarm_ringing,
  output logic [23:0]                time_bcd
);
  localparam logic [8:0] RING_CNT   = 9'(RING_SECONDS);
  localparam logic [8:0] SNOOZE_CNT = 9'(SNOOZE_SECONDS);

  logic       wr_en, wr_status, wr_ctrl, wr_hm, wr_s, wr_alarm;
  logic       hm_ok, s_ok, hm_load, time_load, time_adv;
  logic       snooze_p, stop_p, en_clr_p, match;
  logic [7:0] hh, mm, ss, hh_n, mm_n;
  logic       ss_carry, mm_carry, hh_carry;

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] alarm_q, alarm_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        fired_q, fired_d, werr_q, werr_d;
  logic        ringing_q, ringing_d;
  logic [15:0] rdata_q, rdata_d;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wr_status = wr_en && (bus.address == ADDR_STATUS);
  assign wr_ctrl   = wr_en && (bus.address == ADDR_CONTROL);
  assign wr_hm     = wr_en && (bus.address == ADDR_TIME_HM);
  assign wr_s      = wr_en && (bus.address == ADDR_TIME_S);
  assign wr_alarm  = wr_en && (bus.address == ADDR_ALARM_HM);

  assign hm_ok     = bcd_ok(bus.writedata[15:8], BCD_MAX_HR) && bcd_ok(bus.writedata[7:0], BCD_MAX_MS);
  assign s_ok      = bcd_ok(bus.writedata[7:0], BCD_MAX_MS);
  assign hm_load   = wr_hm && hm_ok;
  assign time_load = hm_load || (wr_s && s_ok);
  // A valid time write swallows a coincident tick entirely.
  assign time_adv  = tick && ctrl_q[CTRL_RUN] && !time_load;

  assign snooze_p  = wr_ctrl && bus.writedata[CTRL_SNOOZE];
  assign stop_p    = wr_ctrl && bus.writedata[CTRL_STOP];
  assign en_clr_p  = wr_ctrl && !bus.writedata[CTRL_ALARM_EN];

  taller_bcd_digit_pair #(.MAX(BCD_MAX_MS)) u_ss (
    .clk(clk), .rst_n(reset_n), .load(time_load),
    .load_val(wr_hm ? 8'h00 : bus.writedata[7:0]),
    .en(time_adv), .value(ss), .carry(ss_carry)
  );
  taller_bcd_digit_pair #(.MAX(BCD_MAX_MS)) u_mm (
    .clk(clk), .rst_n(reset_n), .load(hm_load), .load_val(bus.writedata[7:0]),
    .en(ss_carry), .value(mm), .carry(mm_carry)
  );
  taller_bcd_digit_pair #(.MAX(BCD_MAX_HR)) u_hh (
    .clk(clk), .rst_n(reset_n), .load(hm_load), .load_val(bus.writedata[15:8]),
    .en(mm_carry), .value(hh), .carry(hh_carry)
  );

  // Match looks at the time this tick lands on, which always has seconds 00.
  assign mm_n  = mm_carry ? 8'h00 : bcd_inc(mm);
  assign hh_n  = mm_carry ? (hh_carry ? 8'h00 : bcd_inc(hh)) : hh;
  assign match = ss_carry && ctrl_q[CTRL_ALARM_EN] && (state_q == ST_IDLE) && ({hh_n, mm_n} == alarm_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    alarm_d = alarm_q;
    fired_d = fired_q;
    werr_d  = werr_q;
    rdata_d = 16'h0000;

    if (wr_status) begin
      fired_d = 1'b0;
      werr_d  = 1'b0;
    end
    if (wr_ctrl) ctrl_d = bus.writedata[2:0];
    if (wr_alarm && hm_ok) alarm_d = bus.writedata;
    if (((wr_hm || wr_alarm) && !hm_ok) || (wr_s && !s_ok)) werr_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (match && !stop_p && !en_clr_p) begin
          state_d = ST_RINGING;
          cnt_d   = RING_CNT;
          fired_d = 1'b1;
        end
      end
      ST_RINGING: begin
        if (stop_p || en_clr_p) begin
          state_d = ST_IDLE;
          cnt_d   = 9'd0;
        end else if (snooze_p) begin
          state_d = ST_SNOOZED;
          cnt_d   = SNOOZE_CNT;
        end else if (tick) begin
          if (cnt_q == 9'd1) state_d = ST_IDLE;
          cnt_d = cnt_q - 9'd1;
        end
      end
      ST_SNOOZED: begin
        if (stop_p || en_clr_p) begin
          state_d = ST_IDLE;
          cnt_d   = 9'd0;
        end else if (tick) begin
          if (cnt_q == 9'd1) begin
            state_d = ST_RINGING;
            cnt_d   = RING_CNT;
            fired_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 9'd0;
      end
    endcase

    ringing_d = (state_d == ST_RINGING);

    case (bus.address)
      ADDR_STATUS:   rdata_d = {12'h000, state_q, werr_q, fired_q};
      ADDR_CONTROL:  rdata_d = {13'h0000, ctrl_q};
      ADDR_TIME_HM:  rdata_d = {hh, mm};
      ADDR_TIME_S:   rdata_d = {8'h00, ss};
      ADDR_ALARM_HM: rdata_d = alarm_q;
      ADDR_COUNT:    rdata_d = {7'h00, cnt_q};
      default:       rdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 9'd0;
      ctrl_q    <= 3'd0;
      alarm_q   <= 16'h0000;
      fired_q   <= 1'b0;
      werr_q    <= 1'b0;
      ringing_q <= 1'b0;
      rdata_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      alarm_q   <= alarm_d;
      fired_q   <= fired_d;
      werr_q    <= werr_d;
      ringing_q <= ringing_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.readdata  = rdata_q;
  assign irq           = fired_q && ctrl_q[CTRL_IRQ_EN];
  assign alarm_ringing = ringing_q;
  assign time_bcd      = {hh, mm, ss};
endmodule

// File: tb/tb_taller_alarm_clock.sv
// tb/tb_taller_alarm_clock.sv - directed vector bench for the alarm clock core
module tb_taller_alarm_clock;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        tick = 1'b0;
  logic        irq, alarm_ringing;
  logic [23:0] time_bcd;
  logic [15:0] rdv;

  int n_cmp = 0;
  int n_bad = 0;

  taller_alarm_clock_if bus();

  taller_alarm_clock #(.RING_SECONDS(60), .SNOOZE_SECONDS(300)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .tick(tick),
    .irq(irq), .alarm_ringing(alarm_ringing), .time_bcd(time_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] ra, input logic [15:0] e);
    vec_t v;
    v.do_wr = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    @(posedge clk); #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [15:0] e);
    logic [15:0] d;
    rd(a, d);
    check(name, d, e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
  endtask

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'h0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    check("reset_irq", irq, 1'b0);
    check("reset_ringing", alarm_ringing, 1'b0);
    check("reset_time", time_bcd, 24'h000000);

    for (int a = 0; a < 8; a++) add(1'b0, 3'd0, 16'h0, 3'(a), 16'h0000);
    add(1'b1, 3'd2, 16'h1234, 3'd2, 16'h1234);
    add(1'b1, 3'd3, 16'h0045, 3'd3, 16'h0045);
    add(1'b1, 3'd2, 16'h2460, 3'd2, 16'h1234);
    add(1'b0, 3'd0, 16'h0000, 3'd0, 16'h0002);
    add(1'b1, 3'd0, 16'hFFFF, 3'd0, 16'h0000);
    add(1'b1, 3'd2, 16'h0101, 3'd3, 16'h0000);
    add(1'b1, 3'd3, 16'h005A, 3'd3, 16'h0000);
    add(1'b1, 3'd3, 16'h0060, 3'd0, 16'h0002);
    add(1'b1, 3'd4, 16'h0930, 3'd4, 16'h0930);
    add(1'b1, 3'd4, 16'h1A00, 3'd4, 16'h0930);
    add(1'b1, 3'd1, 16'h001F, 3'd1, 16'h0007);
    add(1'b1, 3'd1, 16'h0000, 3'd1, 16'h0000);
    add(1'b1, 3'd6, 16'hFFFF, 3'd6, 16'h0000);
    add(1'b1, 3'd5, 16'hFFFF, 3'd5, 16'h0000);
    add(1'b1, 3'd2, 16'h0959, 3'd2, 16'h0959);
    add(1'b1, 3'd0, 16'h0000, 3'd0, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, rdv);
      check($sformatf("vec%0d", i), rdv, vecs[i].exp);
    end

    // Day rollover.
    wr(3'd2, 16'h2359); wr(3'd3, 16'h0058); wr(3'd1, 16'h0001);
    ticks(2);
    check("rollover_time", time_bcd, 24'h000000);
    rd_check("rollover_rd_hm", 3'd2, 16'h0000);

    // Alarm fires on the tick into 07:00:00.
    wr(3'd4, 16'h0700); wr(3'd2, 16'h0659); wr(3'd3, 16'h0059); wr(3'd1, 16'h0007);
    ticks(1);
    check("fire_ringing", alarm_ringing, 1'b1);
    check("fire_irq", irq, 1'b1);
    check("fire_time", time_bcd, 24'h070000);
    rd_check("fire_status", 3'd0, 16'h0005);
    wr(3'd0, 16'h0000);
    check("clr_irq", irq, 1'b0);
    check("clr_ringing_stays", alarm_ringing, 1'b1);

    // Snooze, re-ring, auto-stop.
    wr(3'd1, 16'h000F);
    check("snz_ringing", alarm_ringing, 1'b0);
    rd_check("snz_status", 3'd0, 16'h0008);
    rd_check("snz_count", 3'd5, 16'd300);
    ticks(299);
    check("snz_299_ringing", alarm_ringing, 1'b0);
    rd_check("snz_299_count", 3'd5, 16'd1);
    ticks(1);
    check("rering_ringing", alarm_ringing, 1'b1);
    check("rering_irq", irq, 1'b1);
    rd_check("rering_count", 3'd5, 16'd60);
    ticks(59);
    check("ring_59_ringing", alarm_ringing, 1'b1);
    ticks(1);
    check("autostop_ringing", alarm_ringing, 1'b0);
    rd_check("autostop_count", 3'd5, 16'd0);
    rd_check("autostop_status", 3'd0, 16'h0001);

    // Stop beats snooze.
    wr(3'd0, 16'h0000); wr(3'd2, 16'h0659); wr(3'd3, 16'h0059);
    ticks(1);
    check("ring2_ringing", alarm_ringing, 1'b1);
    wr(3'd1, 16'h0017);
    check("stop_ringing", alarm_ringing, 1'b0);
    rd_check("stop_status", 3'd0, 16'h0001);
    rd_check("stop_ctrl", 3'd1, 16'h0007);

    // Clearing alarm_en stops ringing.
    wr(3'd0, 16'h0000); wr(3'd2, 16'h0659); wr(3'd3, 16'h0059);
    ticks(1);
    check("ring3_ringing", alarm_ringing, 1'b1);
    wr(3'd1, 16'h0005);
    check("enclr_ringing", alarm_ringing, 1'b0);
    rd_check("enclr_status", 3'd0, 16'h0001);

    // Writing time equal to the alarm does not fire.
    wr(3'd0, 16'h0000); wr(3'd1, 16'h0007); wr(3'd2, 16'h0700);
    ticks(2);
    check("eqwrite_ringing", alarm_ringing, 1'b0);
    rd_check("eqwrite_status", 3'd0, 16'h0000);
    check("eqwrite_time", time_bcd, 24'h070002);

    // A valid seconds write wins over a coincident tick.
    bus.address = 3'd3; bus.writedata = 16'h0030; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    rd_check("coinc_ss", 3'd3, 16'h0030);

    // Asynchronous reset in the middle of ringing.
    wr(3'd2, 16'h0659); wr(3'd3, 16'h0059);
    ticks(1);
    check("ring4_ringing", alarm_ringing, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_ringing", alarm_ringing, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_time", time_bcd, 24'h000000);
    check("rst_readdata", bus.readdata, 16'h0000);
    @(posedge clk); #1 reset_n = 1'b1;
    rd_check("rst_status", 3'd0, 16'h0000);
    rd_check("rst_ctrl", 3'd1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
